// File: rtl/mac_drain_if.sv
// mac_drain bus bundle: MAC-row snapshot side plus
// the valid/ready read-out stream.
interface mac_drain_if #(
    parameter int N     = 32,
    parameter int LANES = 4,
    parameter int OUT_N = 16
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES*N-1:0] acc_in;
    logic [LANES-1:0]   acc_ovr;
    logic               capture;
    logic               capture_ready;
    logic               acc_clr;
    logic [OUT_N-1:0]   out_data;
    logic [LW-1:0]      out_lane;
    logic               out_sat;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport master (
        input  acc_in, acc_ovr, capture, out_ready,
        output capture_ready, acc_clr, out_data,
        output out_lane, out_sat, out_last, out_valid
    );

    modport slave (
        output acc_in, acc_ovr, capture, out_ready,
        input  capture_ready, acc_clr, out_data,
        input  out_lane, out_sat, out_last, out_valid
    );
endinterface

// File: rtl/mac_drain.sv
// mac_drain: snapshots a MAC row, clears it, and streams
// requantized lane values out one beat per lane.
module mac_drain #(
    parameter int N     = 32,
    parameter int Q     = 10,
    parameter int LANES = 4,
    parameter int OUT_N = 16,
    parameter int OUT_Q = 8
) (
    input  logic clk,
    input  logic rst_n,
    mac_drain_if.master bus,
    output logic busy
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SH = Q - OUT_Q;

    localparam logic signed [N:0] MAXV =
        $signed({{(N-OUT_N+2){1'b0}}, {(OUT_N-1){1'b1}}});
    localparam logic signed [N:0] MINV =
        $signed({{(N-OUT_N+2){1'b1}}, {(OUT_N-1){1'b0}}});
    localparam logic signed [N:0] RND =
        (SH > 0) ? $signed((N+1)'(1) << ((SH > 0) ? SH-1 : 0))
                 : '0;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [N-1:0]      buf_q [LANES];
    logic [LANES-1:0]  ovr_q;
    logic              clr_q;

    logic              take;
    logic              at_last;
    logic [N-1:0]      cur;
    logic signed [N:0] ext;
    logic signed [N:0] shr;
    logic              pos_sat;
    logic              neg_sat;

    assign take    = (state_q == IDLE) && bus.capture;
    assign at_last = (idx_q == LW'(LANES-1));
    assign bus.acc_clr = clr_q;

    // State, lane index and the one-shot clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            clr_q   <= take;
        end
    end

    // Snapshot buffer, loaded only on an accepted capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
            ovr_q <= '0;
        end else if (take) begin
            for (int i = 0; i < LANES; i++)
                buf_q[i] <= bus.acc_in[i*N +: N];
            ovr_q <= bus.acc_ovr;
        end
    end

    // Next state: capture starts a drain, last handshake ends it
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.capture) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (at_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Round-half-up shift of the selected lane, then range test
    always_comb begin
        cur     = buf_q[idx_q];
        ext     = $signed({cur[N-1], cur});
        shr     = (ext + RND) >>> SH;
        pos_sat = (shr > MAXV);
        neg_sat = (shr < MINV);
    end

    // Outputs: stream fields only while draining
    always_comb begin
        bus.capture_ready = (state_q == IDLE);
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_lane      = '0;
        bus.out_sat       = 1'b0;
        bus.out_last      = 1'b0;
        busy              = 1'b0;
        if (state_q == DRAIN) begin
            bus.out_valid = 1'b1;
            busy          = 1'b1;
            bus.out_lane  = idx_q;
            bus.out_last  = at_last;
            bus.out_sat   = pos_sat | neg_sat | ovr_q[idx_q];
            if (pos_sat)
                bus.out_data = MAXV[OUT_N-1:0];
            else if (neg_sat)
                bus.out_data = MINV[OUT_N-1:0];
            else
                bus.out_data = shr[OUT_N-1:0];
        end
    end
endmodule

// File: tb/tb_mac_drain.sv
// tb_mac_drain: directed vectors plus a queue-based
// reference model checked every falling edge.
module tb_mac_drain;
    localparam int N     = 32;
    localparam int Q     = 10;
    localparam int LANES = 4;
    localparam int OUT_N = 16;
    localparam int OUT_Q = 8;
    localparam int SH    = Q - OUT_Q;
    localparam int LW    = $clog2(LANES);

    typedef struct {
        logic [OUT_N-1:0] data;
        int               lane;
        logic             sat;
        logic             last;
    } beat_t;

    logic clk;
    logic rst_n;
    logic busy;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    beat_t q[$];
    logic  exp_clr = 1'b0;

    mac_drain_if #(.N(N), .LANES(LANES), .OUT_N(OUT_N)) bus ();

    mac_drain #(
        .N(N), .Q(Q), .LANES(LANES), .OUT_N(OUT_N), .OUT_Q(OUT_Q)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    // Requantize as plain integer arithmetic
    function automatic logic [OUT_N-1:0] rq(
        input logic [N-1:0] a, output logic s);
        longint v, mx, mn;
        v  = longint'($signed(a));
        mx = (longint'(1) << (OUT_N-1)) - 1;
        mn = -(longint'(1) << (OUT_N-1));
        if (SH > 0) v = v + (longint'(1) << (SH-1));
        v = v >>> SH;
        s = 1'b0;
        if (v > mx) begin v = mx; s = 1'b1; end
        if (v < mn) begin v = mn; s = 1'b1; end
        return v[OUT_N-1:0];
    endfunction

    // Reference model and per-cycle compare
    always @(negedge clk) begin
        beat_t b;
        logic  s;
        if (!rst_n) begin
            q.delete();
            exp_clr = 1'b0;
            chk("rst_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_clr", 64'(bus.acc_clr), 64'd0);
            chk("rst_cready", 64'(bus.capture_ready), 64'd1);
        end else begin
            chk("valid", 64'(bus.out_valid),
                64'(q.size() > 0));
            chk("busy", 64'(busy), 64'(q.size() > 0));
            chk("cready", 64'(bus.capture_ready),
                64'(q.size() == 0));
            chk("acc_clr", 64'(bus.acc_clr), 64'(exp_clr));
            if (q.size() > 0) begin
                chk("beat",
                    {bus.out_data, 8'(bus.out_lane),
                     7'd0, bus.out_sat, 7'd0, bus.out_last},
                    {q[0].data, 8'(q[0].lane),
                     7'd0, q[0].sat, 7'd0, q[0].last});
            end
            exp_clr = (q.size() == 0) && bus.capture;
            if (q.size() > 0) begin
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    hs_cnt++;
                end
            end else if (bus.capture) begin
                for (int i = 0; i < LANES; i++) begin
                    b.data = rq(bus.acc_in[i*N +: N], s);
                    b.sat  = s | bus.acc_ovr[i];
                    b.lane = i;
                    b.last = (i == LANES-1);
                    q.push_back(b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] l0, l1, l2, l3,
                       input logic [3:0] ovr);
        bus.acc_in  = {l3, l2, l1, l0};
        bus.acc_ovr = ovr;
        bus.capture = 1'b1;
        tick();
        bus.capture = 1'b0;
    endtask

    initial begin
        int h0;
        rst_n          = 1'b0;
        bus.acc_in     = '0;
        bus.acc_ovr    = '0;
        bus.capture    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_lane", 64'(bus.out_lane), 64'd0);
        chk("rst_sat", 64'(bus.out_sat), 64'd0);
        chk("rst_last", 64'(bus.out_last), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic drain
        h0 = hs_cnt;
        cap(32'h400, 32'h5, 32'hFFFFFFFA, 32'h0, 4'b0);
        chk("b_clr", 64'(bus.acc_clr), 64'd1);
        chk("b_d0", 64'(bus.out_data), 64'h0100);
        tick();
        chk("b_clr_off", 64'(bus.acc_clr), 64'd0);
        chk("b_d1", 64'(bus.out_data), 64'h0001);
        tick();
        chk("b_d2", 64'(bus.out_data), 64'hFFFF);
        tick();
        chk("b_d3", 64'(bus.out_data), 64'h0000);
        chk("b_last3", 64'(bus.out_last), 64'd1);
        tick();
        chk("b_cready", 64'(bus.capture_ready), 64'd1);
        chk("b_beats", 64'(hs_cnt - h0), 64'd4);
        tick();

        // Saturation
        cap(32'h00080000, 32'hFFF00000, 32'h0, 32'h0, 4'b0);
        chk("s_d0", {48'd0, bus.out_data}, 64'h7FFF);
        chk("s_sat0", 64'(bus.out_sat), 64'd1);
        tick();
        chk("s_d1", {48'd0, bus.out_data}, 64'h8000);
        chk("s_sat1", 64'(bus.out_sat), 64'd1);
        repeat (3) tick();

        // Overflow flag passthrough
        cap(32'h0, 32'h0, 32'h400, 32'h0, 4'b0100);
        chk("o_sat0", 64'(bus.out_sat), 64'd0);
        repeat (2) tick();
        chk("o_d2", 64'(bus.out_data), 64'h0100);
        chk("o_sat2", 64'(bus.out_sat), 64'd1);
        repeat (2) tick();

        // Backpressure on lane 1
        h0 = hs_cnt;
        cap(32'h400, 32'h5, 32'hFFFFFFFA, 32'h0, 4'b0);
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("p_lane", 64'(bus.out_lane), 64'd1);
            chk("p_data", 64'(bus.out_data), 64'h0001);
            chk("p_valid", 64'(bus.out_valid), 64'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("p_beats", 64'(hs_cnt - h0), 64'd4);
        tick();

        // Capture during drain ignored; bubble capture taken
        cap(32'h400, 32'h5, 32'hFFFFFFFA, 32'h0, 4'b0);
        tick();
        cap(32'h7FFFFFFF, 32'h7FFFFFFF,
            32'h7FFFFFFF, 32'h7FFFFFFF, 4'hF);
        chk("c_noclr", 64'(bus.acc_clr), 64'd0);
        chk("c_d2", 64'(bus.out_data), 64'hFFFF);
        tick();
        chk("c_d3", 64'(bus.out_data), 64'h0000);
        tick();
        chk("c_bubble", 64'(bus.capture_ready), 64'd1);
        cap(32'h800, 32'h1, 32'h2, 32'h3, 4'b0);
        chk("c_clr2", 64'(bus.acc_clr), 64'd1);
        chk("c_d0", 64'(bus.out_data), 64'h0200);
        repeat (4) tick();

        // Reset mid-drain, then a fresh drain
        cap(32'h400, 32'h5, 32'hFFFFFFFA, 32'h0, 4'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("r_valid", 64'(bus.out_valid), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_cready", 64'(bus.capture_ready), 64'd1);
        h0 = hs_cnt;
        cap(32'hC00, 32'h0, 32'h0, 32'h0, 4'b0);
        chk("r_lane0", 64'(bus.out_lane), 64'd0);
        chk("r_d0", 64'(bus.out_data), 64'h0300);
        repeat (5) tick();
        chk("r_beats", 64'(hs_cnt - h0), 64'd4);

        // Reset during the clear pulse
        cap(32'h1, 32'h1, 32'h1, 32'h1, 4'b0);
        rst_n = 1'b0;
        #1;
        chk("rc_clr", 64'(bus.acc_clr), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_drain.md
Name: mac_drain

Overview:
- Read-out end of the MAC array.
- Snapshots the accumulators of a row of MAC lanes in one cycle and pulses a clear back to them.
- Streams the captured values out one lane per beat over a valid/ready interface.
- Each value is requantized from Q-format N-bit to OUT_Q-format OUT_N-bit, with rounding and saturation. Sits between the MAC row and the result write-back / output buffer.

Parameters:
- N, 32, accumulator width (signed fixed-point)
- Q, 10, accumulator fractional bits
- LANES, 4, number of MAC lanes captured per snapshot (>=2)
- OUT_N, 16, output data width (signed, OUT_N <= N)
- OUT_Q, 8, output fractional bits (OUT_Q <= Q)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- acc_in  input  LANES*N  MAC accumulator values; lane i = acc_in[i*N +: N]
- acc_ovr  input  LANES  per-lane MAC multiply-overflow flags
- capture  input  1  request to snapshot acc_in
- capture_ready  output  1  high when a capture will be accepted
- acc_clr  output  1  one-cycle clear pulse to MAC lanes
- out_data  output  OUT_N  requantized lane value
- out_lane  output  $clog2(LANES)  lane index of out_data
- out_sat  output  1  value saturated or lane overflow flag set
- out_last  output  1  high on beat for lane LANES-1
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts beat
- busy  output  1  high while in DRAIN

Behaviour:
- Reset: async on rst_n low.
  - state=IDLE, idx=0, buffer cleared.
  - Outputs: out_valid=0, out_data=0, out_lane=0, out_sat=0, out_last=0, acc_clr=0, busy=0, capture_ready=1.
- States: IDLE, DRAIN.
- IDLE:
  - capture_ready=1.
  - On capture=1 at an edge: latch all LANES acc_in words and acc_ovr bits, set idx=0, go to DRAIN.
  - acc_clr=1 for exactly the following cycle (registered), then 0.
- DRAIN:
  - capture_ready=0; a capture pulse here is ignored (no latch, no acc_clr).
  - out_valid=1 and busy=1 the cycle after capture acceptance; latency 1.
  - out_data, out_lane=idx, out_sat and out_last=(idx==LANES-1) derive combinationally from the registered buffer and idx.
  - They stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: idx increments.
  - If idx==LANES-1 on the handshake: idx=0, go to IDLE; out_valid drops the next cycle.
  - Exactly LANES beats per capture, in lane order 0..LANES-1.
  - out_ready may be high continuously; one beat per cycle.
- Back-to-back: capture_ready goes high the cycle after the last handshake (one-cycle bubble); a capture in that IDLE cycle is accepted.
- Requantization, per lane, sh = Q-OUT_Q:
  - Sign-extend to N+1 bits.
  - If sh>0, add 2^(sh-1) (round half up), then arithmetic right shift by sh.
  - If result > 2^(OUT_N-1)-1: output max, sat=1.
  - If result < -2^(OUT_N-1): output min, sat=1.
  - Otherwise output the low OUT_N bits, sat=0.
  - out_sat = sat | latched acc_ovr[idx].
  - sh=0 means no rounding term.
- Reset mid-DRAIN: buffer discarded, no further beats, no acc_clr, IDLE after release.
- Reset during the acc_clr cycle: acc_clr drops immediately (async).
- acc_in is only sampled on an accepted capture; changes at other times have no effect.

Test Plan:
- Basic drain, defaults, out_ready=1: lanes {0x00000400, 0x00000005, 0xFFFFFFFA, 0x00000000}, pulse capture.
  - Required: acc_clr high next cycle.
  - Beats on 4 consecutive cycles: out_data 0x0100, 0x0001, 0xFFFF, 0x0000.
  - out_lane 0..3, out_last only on lane 3, out_sat=0.
  - capture_ready high the cycle after the last beat.
- Saturation: lane0=0x00080000, lane1=0xFFF00000.
  - Required: lane0 out_data=0x7FFF, out_sat=1; lane1 out_data=0x8000, out_sat=1.
- Overflow passthrough: lane2=0x00000400 with acc_ovr[2]=1 at capture.
  - Required: lane2 out_data=0x0100, out_sat=1; other lanes out_sat=0.
- Backpressure: out_ready low for 3 cycles on lane 1.
  - Required: out_data/out_lane/out_sat held stable, out_valid stays 1, no beat lost or duplicated, total beats = 4.
- Capture during DRAIN with changed acc_in.
  - Required: ignored; no second acc_clr; drained values equal the first snapshot.
  - A capture in the bubble cycle after the last beat is accepted.
- rst_n low after beat 1 of 4.
  - Required: out_valid=0 and busy=0 immediately; capture_ready=1 after release.
  - A new capture produces a fresh 4-beat drain starting at lane 0.
